pca_mode_sequencer: RTL and testbench

//  Sits between the i2c_target write port and register_data. It sequences the MODE1 SLEEP/RESTART

---
 rtl/pca_mode_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pca_mode_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pca_mode_sequencer.sv
// MODE1 sleep/wake/restart sequencing and SWRST default replay in front of register_data.
// Single write master toward register_data; all outputs are registered.
//
//  state     | meaning
//  ST_SLEEP  | oscillator off, counter gated, PRE_SCALE writable
//  ST_WAKE   | oscillator settling, wake down-counter running
//  ST_RUN    | counter running, LED writes arm the restart flag
//  ST_SWRST  | replaying power-on defaults, one write per cycle
module pca_mode_sequencer #(
   parameter int WAKE_CYCLES = 12500,
   parameter int WAKE_W      = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] wr_id_i,
   input  logic [7:0] wr_value_i,
   input  logic       wr_en_i,
   input  logic       swrst_i,
   input  logic [7:0] mode1_i,
   output logic [7:0] wr_id_o,
   output logic [7:0] wr_value_o,
   output logic       wr_en_o,
   output logic       counter_run_o,
   output logic       busy_o
);

   localparam logic [7:0] ADDR_MODE1     = 8'h00;
   localparam logic [7:0] ADDR_PRE_SCALE = 8'hFE;
   localparam logic [6:0] REPLAY_LAST    = 7'd70;

   typedef enum logic [1:0] {
      ST_SLEEP,
      ST_WAKE,
      ST_RUN,
      ST_SWRST
   } state_t;

   state_t              state_q, state_d;
   logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
   logic [6:0]          replay_idx_q, replay_idx_d;
   logic                restart_pending_q, restart_pending_d;
   logic                restart_req_q, restart_req_d;
   logic                wr_en_q, wr_en_d;
   logic [7:0]          wr_id_q, wr_id_d;
   logic [7:0]          wr_value_q, wr_value_d;
   logic                counter_run_q, counter_run_d;
   logic                busy_q, busy_d;

   logic                host_fwd;
   logic                host_mode1;
   logic [15:0]         replay_ent;
   logic                mode1_unused;

   assign mode1_unused = mode1_i[7];

   function automatic logic is_led_addr(input logic [7:0] a);
      return ((a >= 8'h06) && (a <= 8'h45)) || ((a >= 8'hFA) && (a <= 8'hFD));
   endfunction

   // Default table: MODE1, MODE2, LED0..15 (full-off set in each OFF_H), ALL_LED, PRE_SCALE.
   function automatic logic [15:0] replay_entry(input logic [6:0] idx);
      logic [7:0] a;
      logic [7:0] v;
      a = 8'h00;
      v = 8'h00;
      if (idx == 7'd0) begin
         a = 8'h00;
         v = 8'h11;
      end else if (idx == 7'd1) begin
         a = 8'h01;
         v = 8'h04;
      end else if (idx <= 7'd65) begin
         a = {1'b0, idx} + 8'd4;
         v = (a[1:0] == 2'b01) ? 8'h10 : 8'h00;
      end else if (idx <= 7'd69) begin
         a = 8'hFA + {1'b0, idx} - 8'd66;
         v = (idx == 7'd69) ? 8'h10 : 8'h00;
      end else begin
         a = 8'hFE;
         v = 8'h1E;
      end
      return {a, v};
   endfunction

   assign replay_ent = replay_entry(replay_idx_q);
   assign host_mode1 = wr_en_i && (wr_id_i == ADDR_MODE1);
   assign host_fwd   = wr_en_i && !((wr_id_i == ADDR_PRE_SCALE) && (state_q != ST_SLEEP));

   always_comb begin
      state_d           = state_q;
      wake_cnt_d        = wake_cnt_q;
      replay_idx_d      = replay_idx_q;
      restart_pending_d = restart_pending_q;
      restart_req_d     = restart_req_q;
      wr_en_d           = 1'b0;
      wr_id_d           = wr_id_q;
      wr_value_d        = wr_value_q;
      busy_d            = 1'b0;
      counter_run_d     = (state_q == ST_RUN);

      if (state_q == ST_SWRST) begin
         wr_en_d    = 1'b1;
         busy_d     = 1'b1;
         wr_id_d    = replay_ent[15:8];
         wr_value_d = replay_ent[7:0];
         if (replay_idx_q == REPLAY_LAST) begin
            state_d      = ST_SLEEP;
            replay_idx_d = '0;
         end else begin
            replay_idx_d = replay_idx_q + 7'd1;
         end
      end else if (swrst_i) begin
         // replay_idx_q is 0 outside replay, so entry 0 goes out on the request edge
         state_d           = ST_SWRST;
         replay_idx_d      = 7'd1;
         wake_cnt_d        = '0;
         restart_pending_d = 1'b0;
         restart_req_d     = 1'b0;
         wr_en_d           = 1'b1;
         busy_d            = 1'b1;
         wr_id_d           = replay_ent[15:8];
         wr_value_d        = replay_ent[7:0];
      end else begin
         if (host_fwd) begin
            wr_en_d    = 1'b1;
            wr_id_d    = wr_id_i;
            wr_value_d = wr_value_i;
            if (host_mode1) begin
               if (wr_value_i[7]) begin
                  wr_value_d[7]     = 1'b0;
                  restart_pending_d = 1'b0;
               end else begin
                  wr_value_d[7] = restart_pending_q;
               end
            end
         end
         if (wr_en_i && is_led_addr(wr_id_i) && (state_q == ST_RUN)) begin
            restart_pending_d = 1'b1;
         end

         unique case (state_q)
            ST_SLEEP: begin
               if (host_mode1 && !wr_value_i[4]) begin
                  state_d    = ST_WAKE;
                  wake_cnt_d = WAKE_W'(WAKE_CYCLES - 1);
               end
            end
            ST_WAKE: begin
               if (host_mode1 && wr_value_i[4]) begin
                  state_d    = ST_SLEEP;
                  wake_cnt_d = '0;
               end else if (wake_cnt_q == '0) begin
                  state_d       = ST_RUN;
                  restart_req_d = restart_pending_q;
               end else begin
                  wake_cnt_d = wake_cnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (host_mode1 && wr_value_i[4]) begin
                  state_d = ST_SLEEP;
               end
            end
            default: state_d = ST_SLEEP;
         endcase

         if (state_d != ST_RUN) begin
            restart_req_d = 1'b0;
         end
         // A forwarded host write owns the port this cycle; the restart write retries next cycle
         if (restart_req_d && !host_fwd) begin
            wr_en_d       = 1'b1;
            wr_id_d       = ADDR_MODE1;
            wr_value_d    = {1'b1, mode1_i[6:0]};
            restart_req_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q           <= ST_SLEEP;
         wake_cnt_q        <= '0;
         replay_idx_q      <= '0;
         restart_pending_q <= 1'b0;
         restart_req_q     <= 1'b0;
         wr_en_q           <= 1'b0;
         wr_id_q           <= '0;
         wr_value_q        <= '0;
         counter_run_q     <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         wake_cnt_q        <= wake_cnt_d;
         replay_idx_q      <= replay_idx_d;
         restart_pending_q <= restart_pending_d;
         restart_req_q     <= restart_req_d;
         wr_en_q           <= wr_en_d;
         wr_id_q           <= wr_id_d;
         wr_value_q        <= wr_value_d;
         counter_run_q     <= counter_run_d;
         busy_q            <= busy_d;
      end
   end

   assign wr_en_o       = wr_en_q;
   assign wr_id_o       = wr_id_q;
   assign wr_value_o    = wr_value_q;
   assign counter_run_o = counter_run_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_pca_mode_sequencer.sv
// Bench for pca_mode_sequencer: directed scenarios plus random traffic against a
// timestamp/queue based behavioural model of the mode sequencing rules.
module tb_pca_mode_sequencer;

   localparam int WAKE = 24;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [7:0] wr_id_i, wr_value_i, mode1_i;
   logic       wr_en_i, swrst_i;
   logic [7:0] wr_id_o, wr_value_o;
   logic       wr_en_o, counter_run_o, busy_o;

   int n_chk  = 0;
   int n_fail = 0;

   pca_mode_sequencer #(.WAKE_CYCLES(WAKE), .WAKE_W(16)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .wr_id_i       (wr_id_i),
      .wr_value_i    (wr_value_i),
      .wr_en_i       (wr_en_i),
      .swrst_i       (swrst_i),
      .mode1_i       (mode1_i),
      .wr_id_o       (wr_id_o),
      .wr_value_o    (wr_value_o),
      .wr_en_o       (wr_en_o),
      .counter_run_o (counter_run_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: mode as an int, wake as an absolute deadline, replay as a queue.
   localparam int M_SLEEP = 0, M_WAKING = 1, M_RUNNING = 2, M_REPLAY = 3;
   int          m_mode;
   int          m_cyc = 0;
   int          m_run_at;
   logic        m_pending, m_restart_due;
   logic [15:0] m_rq[$];
   logic        e_en, e_run, e_busy;
   logic [7:0]  e_id, e_val;

   function automatic logic is_led(input logic [7:0] a);
      return (a >= 8'h06 && a <= 8'h45) || (a >= 8'hFA && a <= 8'hFD);
   endfunction

   task automatic build_defaults();
      m_rq.delete();
      m_rq.push_back(16'h0011);
      m_rq.push_back(16'h0104);
      for (int a = 6; a <= 'h45; a++)
         m_rq.push_back({8'(a), (a % 4 == 1) ? 8'h10 : 8'h00});
      m_rq.push_back(16'hFA00);
      m_rq.push_back(16'hFB00);
      m_rq.push_back(16'hFC00);
      m_rq.push_back(16'hFD10);
      m_rq.push_back(16'hFE1E);
   endtask

   task automatic model_reset();
      m_mode = M_SLEEP;
      m_pending = 1'b0;
      m_restart_due = 1'b0;
      m_rq.delete();
   endtask

   task automatic model_step();
      logic fwd, old_pending, sleep_req, wake_req;
      logic [15:0] w;
      e_run  = (m_mode == M_RUNNING);
      e_en   = 1'b0;
      e_busy = 1'b0;
      if (m_mode == M_REPLAY || swrst_i) begin
         if (m_mode != M_REPLAY) begin
            build_defaults();
            m_mode = M_REPLAY;
            m_pending = 1'b0;
            m_restart_due = 1'b0;
         end
         w = m_rq.pop_front();
         e_en = 1'b1; e_busy = 1'b1;
         e_id = w[15:8]; e_val = w[7:0];
         if (m_rq.size() == 0) m_mode = M_SLEEP;
      end else begin
         fwd = wr_en_i && !(wr_id_i == 8'hFE && m_mode != M_SLEEP);
         old_pending = m_pending;
         if (fwd) begin
            e_en = 1'b1; e_id = wr_id_i; e_val = wr_value_i;
            if (wr_id_i == 8'h00) begin
               if (wr_value_i[7]) m_pending = 1'b0;
               e_val[7] = wr_value_i[7] ? 1'b0 : old_pending;
            end
         end
         if (wr_en_i && is_led(wr_id_i) && m_mode == M_RUNNING) m_pending = 1'b1;
         sleep_req = wr_en_i && wr_id_i == 8'h00 && wr_value_i[4];
         wake_req  = wr_en_i && wr_id_i == 8'h00 && !wr_value_i[4];
         if (m_mode == M_SLEEP && wake_req) begin
            m_mode = M_WAKING;
            m_run_at = m_cyc + WAKE;
         end else if (m_mode == M_WAKING && sleep_req) begin
            m_mode = M_SLEEP;
         end else if (m_mode == M_WAKING && m_cyc == m_run_at) begin
            m_mode = M_RUNNING;
            m_restart_due = old_pending;
         end else if (m_mode == M_RUNNING && sleep_req) begin
            m_mode = M_SLEEP;
         end
         if (m_mode != M_RUNNING) m_restart_due = 1'b0;
         if (m_restart_due && !fwd) begin
            e_en = 1'b1; e_id = 8'h00; e_val = {1'b1, mode1_i[6:0]};
            m_restart_due = 1'b0;
         end
      end
      m_cyc++;
   endtask

   task automatic drive(input logic en, input logic [7:0] id, input logic [7:0] val, input logic sw);
      wr_en_i = en; wr_id_i = id; wr_value_i = val; swrst_i = sw;
      model_step();
      @(posedge clk_i); #1;
      chk("wr_en", wr_en_o, e_en);
      if (e_en) begin
         chk("wr_id", wr_id_o, e_id);
         chk("wr_value", wr_value_o, e_val);
      end
      chk("counter_run", counter_run_o, e_run);
      chk("busy", busy_o, e_busy);
      wr_en_i = 1'b0; swrst_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   logic [15:0] seen[71];
   int          busy_cnt;
   int          lat;

   initial begin
      rst_ni = 1'b0;
      wr_en_i = 1'b0; swrst_i = 1'b0; wr_id_i = 8'h00; wr_value_i = 8'h00; mode1_i = 8'h01;
      model_reset();
      #12;
      chk("rst_wr_en", wr_en_o, 1'b0);
      chk("rst_wr_id", wr_id_o, 8'h00);
      chk("rst_wr_value", wr_value_o, 8'h00);
      chk("rst_run", counter_run_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // 1: PRE_SCALE writable while asleep, then wake latency
      drive(1'b1, 8'hFE, 8'h79, 1'b0);
      chk("t1_ps_en", wr_en_o, 1'b1);
      chk("t1_ps_val", {wr_id_o, wr_value_o}, 16'hFE79);
      drive(1'b1, 8'h00, 8'h01, 1'b0);
      lat = 0;
      for (int i = 1; i <= WAKE + 4; i++) begin
         drive(1'b0, 8'h00, 8'h00, 1'b0);
         if (counter_run_o && lat == 0) lat = i;
      end
      chk("t1_wake_lat", lat, WAKE + 1);

      // 2: PRE_SCALE protected in RUN, sleep gates the counter one cycle late
      drive(1'b1, 8'hFE, 8'h03, 1'b0);
      chk("t2_ps_drop", wr_en_o, 1'b0);
      drive(1'b1, 8'h00, 8'h11, 1'b0);
      chk("t2_run_still", counter_run_o, 1'b1);
      idle(1);
      chk("t2_run_off", counter_run_o, 1'b0);

      // 3: LED write in RUN arms restart; wake issues internal MODE1 write
      drive(1'b1, 8'h00, 8'h01, 1'b0);
      idle(WAKE + 1);
      drive(1'b1, 8'h06, 8'h55, 1'b0);
      drive(1'b1, 8'h00, 8'h11, 1'b0);
      chk("t3_sleep_fwd", wr_value_o, 8'h91);
      drive(1'b1, 8'h00, 8'h01, 1'b0);
      idle(WAKE - 1);
      idle(1);
      chk("t3_int_en", wr_en_o, 1'b1);
      chk("t3_int_wr", {wr_id_o, wr_value_o}, 16'h0081);
      idle(1);
      chk("t3_run", counter_run_o, 1'b1);
      drive(1'b1, 8'h00, 8'h81, 1'b0);
      chk("t3_clear_fwd", wr_value_o, 8'h01);
      drive(1'b1, 8'h00, 8'h01, 1'b0);
      chk("t3_cleared", wr_value_o, 8'h01);

      // 5: host MODE1 write collides with the restart write
      drive(1'b1, 8'h06, 8'hAA, 1'b0);
      drive(1'b1, 8'h00, 8'h10, 1'b0);
      drive(1'b1, 8'h00, 8'h00, 1'b0);
      idle(WAKE - 1);
      mode1_i = 8'h2A;
      drive(1'b1, 8'h00, 8'h05, 1'b0);
      chk("t5_host_first", {wr_id_o, wr_value_o}, 16'h0085);
      idle(1);
      chk("t5_int_next", {7'd0, wr_en_o, wr_id_o, wr_value_o}, 32'h0001_00AA);
      drive(1'b1, 8'h00, 8'h80, 1'b0);

      // 4: SWRST mid-wake, host traffic and repeated swrst dropped
      drive(1'b1, 8'h00, 8'h10, 1'b0);
      drive(1'b1, 8'h00, 8'h00, 1'b0);
      idle(5);
      busy_cnt = 0;
      for (int i = 0; i < 71; i++) begin
         if (i == 0) drive(1'b1, 8'h06, 8'h33, 1'b1);
         else drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 3) == 0));
         seen[i] = {wr_id_o, wr_value_o};
         if (busy_o && wr_en_o) busy_cnt++;
      end
      chk("t4_busy_cycles", busy_cnt, 71);
      chk("t4_w0", seen[0], 16'h0011);
      chk("t4_w5", seen[5], 16'h0910);
      chk("t4_w65", seen[65], 16'h4510);
      chk("t4_w70", seen[70], 16'hFE1E);
      idle(1);
      chk("t4_busy_end", busy_o, 1'b0);
      chk("t4_run_end", counter_run_o, 1'b0);
      drive(1'b1, 8'hFE, 8'h12, 1'b0);
      chk("t4_sleep_ps", {7'd0, wr_en_o, wr_id_o, wr_value_o}, 32'h0001_FE12);

      // 6: async reset at write 30 of replay
      for (int i = 0; i < 30; i++) drive(1'b0, 8'h00, 8'h00, i == 0);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_async_en", wr_en_o, 1'b0);
      chk("t6_async_id", wr_id_o, 8'h00);
      chk("t6_async_val", wr_value_o, 8'h00);
      chk("t6_async_busy", busy_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         chk("t6_held_en", wr_en_o, 1'b0);
      end
      model_reset();
      rst_ni = 1'b1;
      drive(1'b1, 8'hFE, 8'h12, 1'b0);
      chk("t6_sleep_ps", wr_en_o, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         logic [7:0] id;
         int r;
         r = $urandom_range(0, 9);
         if (r <= 2) id = 8'h00;
         else if (r == 3) id = 8'hFE;
         else if (r <= 5) id = 8'($urandom_range(6, 'h45));
         else if (r == 6) id = 8'($urandom_range('hFA, 'hFD));
         else if (r == 7) id = 8'h01;
         else id = 8'($urandom_range(0, 255));
         mode1_i = 8'($urandom_range(0, 255));
         drive(1'($urandom_range(0, 99) < 45), id, 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 399) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
